// File: rtl/downsample2x2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : downsample2x2_ctrl
// Description : Micro-sequencer for 2x2 box-filter downsampling. Drives the
//               accumulator op code, R load strobe and data-memory address /
//               write strobe to average each 2x2 block of source pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module downsample2x2_ctrl #(
    parameter int                ADDR_W   = 18,
    parameter int                DIM_W    = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = 18'h20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  nrows,
    input  logic [DIM_W-1:0]  ncols,
    output logic [4:0]        ac_enables,
    output logic              r_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0]       C_AC_NOP   = 5'b00000;
    localparam logic [4:0]       C_AC_CLR   = 5'b01011;
    localparam logic [4:0]       C_AC_LDMEM = 5'b01110;
    localparam logic [4:0]       C_AC_ADD   = 5'b01001;
    localparam logic [4:0]       C_AC_SHR   = 5'b01000;
    localparam logic [DIM_W-1:0] C_DIM_ONE  = DIM_W'(1);

    typedef enum logic [4:0] {
        S_IDLE, S_SETUP,
        S_C0, S_L0, S_M0,
        S_C1, S_L1, S_A1, S_M1,
        S_C2, S_L2, S_A2, S_M2,
        S_C3, S_L3, S_A3,
        S_S1, S_S2, S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [DIM_W-1:0]  r_orows;
    logic [DIM_W-1:0]  r_ocols;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_ncols;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] w_col_ptr_nxt;
    logic [ADDR_W-1:0] w_row_step;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_empty;

    // Per-state control word {ac_enables, r_load, mem_we}
    function automatic logic [6:0] ctl_of(input state_t s);
        logic [6:0] v;
        v = {C_AC_NOP, 1'b0, 1'b0};
        case (s)
            S_C0, S_C1, S_C2, S_C3: v = {C_AC_CLR,   1'b0, 1'b0};
            S_L0, S_L1, S_L2, S_L3: v = {C_AC_LDMEM, 1'b0, 1'b0};
            S_A1, S_A2, S_A3:       v = {C_AC_ADD,   1'b0, 1'b0};
            S_M0, S_M1, S_M2:       v = {C_AC_NOP,   1'b1, 1'b0};
            S_S1, S_S2:             v = {C_AC_SHR,   1'b0, 1'b0};
            S_WR:                   v = {C_AC_NOP,   1'b0, 1'b1};
            default:                v = {C_AC_NOP,   1'b0, 1'b0};
        endcase
        return v;
    endfunction

    assign w_last_col = (r_col == r_ocols - C_DIM_ONE);
    assign w_last_row = (r_row == r_orows - C_DIM_ONE);
    assign w_empty    = (r_orows == '0) || (r_ocols == '0);
    assign w_row_step = r_ncols << 1;

    // Next-state sequencing and the p0 address of the next output pixel
    always_comb begin
        w_nxt         = r_state;
        w_col_ptr_nxt = r_col_ptr;
        case (r_state)
            S_IDLE:  w_nxt = start ? S_SETUP : S_IDLE;
            S_SETUP: begin
                w_nxt         = w_empty ? S_DONE : S_C0;
                w_col_ptr_nxt = SRC_BASE;
            end
            S_C0:    w_nxt = S_L0;
            S_L0:    w_nxt = S_M0;
            S_M0:    w_nxt = S_C1;
            S_C1:    w_nxt = S_L1;
            S_L1:    w_nxt = S_A1;
            S_A1:    w_nxt = S_M1;
            S_M1:    w_nxt = S_C2;
            S_C2:    w_nxt = S_L2;
            S_L2:    w_nxt = S_A2;
            S_A2:    w_nxt = S_M2;
            S_M2:    w_nxt = S_C3;
            S_C3:    w_nxt = S_L3;
            S_L3:    w_nxt = S_A3;
            S_A3:    w_nxt = S_S1;
            S_S1:    w_nxt = S_S2;
            S_S2:    w_nxt = S_WR;
            S_WR: begin
                if (!w_last_col) begin
                    w_nxt         = S_C0;
                    w_col_ptr_nxt = r_col_ptr + ADDR_W'(2);
                end else if (!w_last_row) begin
                    w_nxt         = S_C0;
                    w_col_ptr_nxt = r_row_base + w_row_step;
                end else begin
                    w_nxt = S_DONE;
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, registered outputs for the upcoming state, and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            ac_enables <= C_AC_NOP;
            r_load     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            r_orows    <= '0;
            r_ocols    <= '0;
            r_ncols    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_col_ptr  <= '0;
            r_dst_ptr  <= '0;
        end else begin
            r_state                      <= w_nxt;
            {ac_enables, r_load, mem_we} <= ctl_of(w_nxt);
            done                         <= (w_nxt == S_DONE);
            busy                         <= (w_nxt != S_IDLE);
            r_col_ptr                    <= w_col_ptr_nxt;

            // Pixel address is presented in the CLR cycle and held through LD
            case (w_nxt)
                S_C0:    mem_addr <= w_col_ptr_nxt;
                S_C1:    mem_addr <= r_col_ptr + ADDR_W'(1);
                S_C2:    mem_addr <= r_col_ptr + r_ncols;
                S_C3:    mem_addr <= r_col_ptr + r_ncols + ADDR_W'(1);
                S_WR:    mem_addr <= r_dst_ptr;
                default: mem_addr <= mem_addr;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_orows <= nrows >> 1;
                        r_ocols <= ncols >> 1;
                        r_ncols <= ADDR_W'(ncols);
                    end
                end
                S_SETUP: begin
                    r_row      <= '0;
                    r_col      <= '0;
                    r_row_base <= SRC_BASE;
                    r_dst_ptr  <= DST_BASE;
                end
                S_WR: begin
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    if (!w_last_col) begin
                        r_col <= r_col + C_DIM_ONE;
                    end else begin
                        r_col      <= '0;
                        r_row      <= r_row + C_DIM_ONE;
                        r_row_base <= r_row_base + w_row_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/downsample2x2_ctrl.md
Name: downsample2x2_ctrl

Overview:
- Micro-sequencer that drives the accumulator's 5-bit enable code, the R-register load strobe and the data-memory address/write strobe.
- Performs 2x2 box-filter downsampling: for each output pixel, reads the 4 source pixels, sums them in AC via R, divides by 4 with two right shifts, and writes AC[7:0] back to memory.
- Sits beside the main control unit; owns the AC/R/memory controls only while busy.

Parameters:
- ADDR_W, 18, memory address width (matches the 18-bit NA path).
- DIM_W, 16, width of the nrows/ncols inputs.
- SRC_BASE, 0, base address of the source image (row-major, 1 byte per pixel).
- DST_BASE, 18'h20000, base address of the destination image.

Ports:
- clk  in  1  clock; all state updates on the rising edge (AC acts on the falling edge of the same cycle).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- nrows  in  DIM_W  source rows; sampled on accepted start.
- ncols  in  DIM_W  source columns; sampled on accepted start.
- ac_enables  out  5  AC operation code.
- r_load  out  1  R <= AC at the end of this cycle.
- mem_addr  out  ADDR_W  read or write address.
- mem_we  out  1  write AC[7:0] to mem_addr.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: ac_enables=5'b00000 (AC no-op), r_load=0, mem_we=0, mem_addr=0, busy=0, done=0, state=IDLE. Reset mid-operation aborts at once with no further writes; AC/R contents are left as they are.
- Outside the issuing states, ac_enables=0, r_load=0 and mem_we=0.
- AC codes used: CLR=5'b01011, LDMEM=5'b01110, ADD=5'b01001, SHR=5'b01000.
- Memory is synchronous with 1-cycle read latency. Each pixel address is driven in its CLR cycle and held through its LD cycle.
- Output geometry: orows = nrows>>1, ocols = ncols>>1. An odd last row or column is dropped.
- If orows==0 or ocols==0, go IDLE -> DONE with no memory writes.
- Per output pixel (r,c), the taps are p0=(2r,2c), p1=(2r,2c+1), p2=(2r+1,2c), p3=(2r+1,2c+1).
- Source address = SRC_BASE + row*ncols + col.
- Per-pixel sequence, 17 cycles:
  - p0: C0 CLR, L0 LDMEM, M0 r_load.
  - p1: C1 CLR, L1 LDMEM, A1 ADD, M1 r_load.
  - p2: C2 CLR, L2 LDMEM, A2 ADD, M2 r_load.
  - p3: C3 CLR, L3 LDMEM, A3 ADD.
  - Divide and write: S1 SHR, S2 SHR, WR.
- WR cycle: mem_we=1, mem_addr = DST_BASE + r*ocols + c.
- Sum is at most 1020 (10 bits); the result after the shifts is at most 255.
- Address arithmetic uses no multipliers:
  - src_row_base starts at SRC_BASE and advances by 2*ncols per output row.
  - dst_ptr starts at DST_BASE and increments by 1 after each WR.
  - All address sums are modulo 2^ADDR_W (wrap, no error flag).
- After WR:
  - if c < ocols-1: c++, go to C0;
  - else if r < orows-1: c=0, r++, go to C0;
  - else go to DONE.
- DONE: done=1 for one cycle, busy=1, then return to IDLE with busy=0.
- start while busy, or in the DONE cycle, is ignored. start in the same cycle as reset is ignored.
- Total latency from accepted start to done = 1 + 17*orows*ocols + 1 cycles.

Test Plan:
- 4x4 image, pixels 0..15 at SRC_BASE, start -> 4 writes at DST_BASE..+3 with values 2, 4, 10, 12; done 70 cycles after start; busy low the cycle after.
- 2x2 all 8'hFF -> single write of 8'hFF (sum 1020 >> 2); during the first pixel, ac_enables sequence exactly 0B,0E,00,0B,0E,09,00,0B,0E,09,00,0B,0E,09,08,08,00, with r_load high in cycles 3, 7 and 11 only.
- 3x5 odd image -> orows=1, ocols=2; 2 writes; row 2 and column 4 never addressed; source addresses 0,1,5,6 then 2,3,7,8.
- nrows=1, ncols=8 -> no mem_we ever; done pulses 2 cycles after start.
- reset asserted in the L2 cycle of pixel 1 -> next cycle all outputs at reset values and no WR occurs. A new start then runs the full job from pixel 0 correctly.
- start pulsed again mid-job, plus start held high during DONE -> ignored; exactly one done pulse and one set of writes.
